// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One access is issued per cycle; reads return one cycle later on a shared
// rdata bus, tagged to the owning requester by rvalid0/rvalid1.
module mem_arbiter #(
    parameter int WIDTH        = 16,
    parameter int RAM_adr_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [RAM_adr_BITS-1:0] adr0,
    input  logic [RAM_adr_BITS-1:0] adr1,
    input  logic [WIDTH-1:0]        wdata0,
    input  logic [WIDTH-1:0]        wdata1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    rvalid0,
    output logic                    rvalid1,
    output logic [WIDTH-1:0]        rdata,
    output logic                    mem_en,
    output logic                    mem_write,
    output logic [RAM_adr_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]        mem_din,
    input  logic [WIDTH-1:0]        mem_dout
);

    // last_q = 1 means requester 1 was granted most recently, so requester 0
    // wins the next contended cycle. Reset leaves it at 1.
    logic last_q;
    logic last_d;
    // One outstanding read at most: the RAM answers in the following cycle.
    logic pend_valid_q;
    logic pend_valid_d;
    logic pend_owner_q;
    logic pend_owner_d;

    // Grant selection: a lone requester wins at once, contention goes to the
    // requester that was not granted last; nothing is granted during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else begin
            case ({req1, req0})
                2'b01: begin
                    gnt0 = 1'b1;
                end
                2'b10: begin
                    gnt1 = 1'b1;
                end
                2'b11: begin
                    if (last_q) begin
                        gnt0 = 1'b1;
                    end else begin
                        gnt1 = 1'b1;
                    end
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    // RAM command mux: requester 0's address/data are presented whenever
    // requester 1 is not the one being granted, including idle cycles.
    always_comb begin
        mem_en = gnt0 | gnt1;
        if (gnt1) begin
            mem_adr   = adr1;
            mem_din   = wdata1;
            mem_write = we1 & mem_en;
        end else begin
            mem_adr   = adr0;
            mem_din   = wdata0;
            mem_write = we0 & mem_en;
        end
    end

    // Next-state: track who was granted last and whether a read is in flight.
    always_comb begin
        last_d       = last_q;
        pend_valid_d = 1'b0;
        pend_owner_d = pend_owner_q;
        if (reset) begin
            last_d       = 1'b1;
            pend_valid_d = 1'b0;
            pend_owner_d = 1'b0;
        end else if (mem_en) begin
            last_d       = gnt1;
            pend_valid_d = ~mem_write;
            pend_owner_d = gnt1;
        end else begin
            last_d       = last_q;
            pend_valid_d = 1'b0;
            pend_owner_d = pend_owner_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q       <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_owner_q <= 1'b0;
        end else begin
            last_q       <= last_d;
            pend_valid_q <= pend_valid_d;
            pend_owner_q <= pend_owner_d;
        end
    end

    // Read return: steer the in-flight read's valid to its owner. A read that
    // would land while reset is high is suppressed, since its requester is
    // being reset along with the arbiter.
    always_comb begin
        rdata   = mem_dout;
        rvalid0 = 1'b0;
        rvalid1 = 1'b0;
        if (pend_valid_q && !reset) begin
            rvalid0 = ~pend_owner_q;
            rvalid1 = pend_owner_q;
        end else begin
            rvalid0 = 1'b0;
            rvalid1 = 1'b0;
        end
    end

endmodule
